// File: rtl/chip8_stack_ctrl.sv
// CHIP-8 call/return stack controller: sequences push/pop handshakes to an
// external stack, tracks depth, and reports overflow/underflow as a sticky fault.
module chip8_stack_ctrl #(
  parameter int DEPTH   = 16,
  parameter int WE_HOLD = 2,
  parameter int POP_LAT = 1
) (
  input  logic        cpu_clk,
  input  logic        reset_n,
  input  logic        call_req,
  input  logic        ret_req,
  input  logic [15:0] ret_addr_in,
  input  logic        clear_err,
  input  logic [15:0] stk_outdata,
  output logic [1:0]  stk_we,
  output logic [15:0] stk_writedata,
  output logic        busy,
  output logic        done,
  output logic [15:0] ret_pc,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [4:0]  depth
);

  typedef enum logic [2:0] {IDLE, PUSH, POP, POP_WAIT, DONE, ERR} state_t;

  localparam logic [4:0] DEPTH_MAX = 5'(DEPTH);
  localparam logic [2:0] HOLD_LAST = 3'(WE_HOLD - 1);
  localparam logic [2:0] LAT_LAST  = 3'(POP_LAT - 1);

  state_t      r_state, w_next;
  logic [2:0]  r_cnt;
  logic        r_err_pulse;
  logic        r_error;
  logic [1:0]  r_err_code;
  logic [4:0]  r_depth;
  logic [15:0] r_wdata, r_ret_pc;

  logic        w_cnt_clr, w_latch_wd, w_ld_pc, w_inc, w_dec, w_set_err, w_clr_err;
  logic [1:0]  w_err_code;

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    stk_we     = 2'b00;
    w_cnt_clr  = 1'b0;
    w_latch_wd = 1'b0;
    w_ld_pc    = 1'b0;
    w_inc      = 1'b0;
    w_dec      = 1'b0;
    w_set_err  = 1'b0;
    w_clr_err  = 1'b0;
    w_err_code = 2'b00;
    case (r_state)
      IDLE: if (!r_error) begin
        // call has priority; a simultaneous ret is simply dropped
        if (call_req) begin
          if (r_depth == DEPTH_MAX) begin
            w_next = ERR; w_set_err = 1'b1; w_err_code = 2'b01;
          end else begin
            w_next = PUSH; w_latch_wd = 1'b1; w_cnt_clr = 1'b1;
          end
        end else if (ret_req) begin
          if (r_depth == 5'd0) begin
            w_next = ERR; w_set_err = 1'b1; w_err_code = 2'b10;
          end else begin
            w_next = POP; w_cnt_clr = 1'b1;
          end
        end
      end
      PUSH: begin
        stk_we = 2'b01;
        if (r_cnt == HOLD_LAST) begin
          w_next = DONE; w_inc = 1'b1;
        end
      end
      POP: begin
        stk_we = 2'b10;
        if (r_cnt == HOLD_LAST) begin
          if (POP_LAT == 0) begin
            w_next = DONE; w_ld_pc = 1'b1; w_dec = 1'b1;
          end else begin
            w_next = POP_WAIT; w_cnt_clr = 1'b1;
          end
        end
      end
      POP_WAIT: if (r_cnt == LAT_LAST) begin
        w_next = DONE; w_ld_pc = 1'b1; w_dec = 1'b1;
      end
      DONE: w_next = IDLE;
      ERR: if (clear_err) begin
        w_next = IDLE; w_clr_err = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= 3'd0;
      r_err_pulse <= 1'b0;
      r_error     <= 1'b0;
      r_err_code  <= 2'b00;
      r_depth     <= 5'd0;
      r_wdata     <= 16'h0000;
      r_ret_pc    <= 16'h0000;
    end else begin
      r_cnt       <= w_cnt_clr ? 3'd0 : r_cnt + 3'd1;
      // done for a fault is a single pulse on ERR entry, not for the whole stay
      r_err_pulse <= w_set_err;
      if (w_set_err) begin
        r_error    <= 1'b1;
        r_err_code <= w_err_code;
      end else if (w_clr_err) begin
        r_error    <= 1'b0;
        r_err_code <= 2'b00;
      end
      if (w_inc)      r_depth  <= r_depth + 5'd1;
      else if (w_dec) r_depth  <= r_depth - 5'd1;
      if (w_latch_wd) r_wdata  <= ret_addr_in;
      if (w_ld_pc)    r_ret_pc <= stk_outdata;
    end
  end

  assign stk_writedata = r_wdata;
  assign busy          = (r_state != IDLE);
  assign done          = (r_state == DONE) | r_err_pulse;
  assign ret_pc        = r_ret_pc;
  assign error         = r_error;
  assign err_code      = r_err_code;
  assign depth         = r_depth;

endmodule

// File: doc/chip8_stack_ctrl.md
CHIP8_STACK_CTRL -- requirements
Module: chip8_stack_ctrl

Interface
REQ-001 Parameter DEPTH, default 16: stack capacity in entries.
REQ-002 Parameter WE_HOLD, default 2: cycles stk_we is held per push/pop (1..7).
REQ-003 Parameter POP_LAT, default 1: cycles after stk_we release before stk_outdata is valid (0..7).
REQ-004 cpu_clk  input  1  single clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 call_req  input  1  one-cycle request to push ret_addr_in (CHIP-8 2NNN).
REQ-007 ret_req  input  1  one-cycle request to pop into ret_pc (CHIP-8 00EE).
REQ-008 ret_addr_in  input  16  value to push on call.
REQ-009 clear_err  input  1  clears sticky error.
REQ-010 stk_outdata  input  16  stack read data.
REQ-011 stk_we  output  2  stack command: 00 idle, 01 push, 10 pop; 11 never driven.
REQ-012 stk_writedata  output  16  push data to stack.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 ret_pc  output  16  last popped value.
REQ-016 error  output  1  sticky fault flag.
REQ-017 err_code  output  2  01 overflow, 10 underflow, 00 none.
REQ-018 depth  output  5  current entry count, 0..DEPTH.

Function
REQ-019 FSM states: IDLE, PUSH, POP, POP_WAIT, DONE, ERR.
REQ-020 Requests are sampled only in IDLE with error=0; requests in any other state or while error=1 are dropped, not queued.
REQ-021 call_req and ret_req in the same IDLE cycle: call wins; ret is dropped.
REQ-022 Call accepted at cycle N with depth<DEPTH: stk_writedata latched from ret_addr_in at N; stk_we=01 for cycles N+1..N+WE_HOLD; done=1 at N+WE_HOLD+1; depth increments in the done cycle.
REQ-023 stk_writedata holds its value until the next accepted call.
REQ-024 Ret accepted at N with depth>0: stk_we=10 for N+1..N+WE_HOLD; POP_WAIT for POP_LAT cycles; ret_pc loads stk_outdata at the edge ending POP_WAIT (end of POP when POP_LAT=0); done=1 and ret_pc valid at N+WE_HOLD+POP_LAT+1; depth decrements in the done cycle.
REQ-025 ret_pc holds its value until the next successful pop.
REQ-026 DONE lasts exactly one cycle and returns to IDLE; back-to-back requests are accepted in the cycle after done.
REQ-027 Call with depth==DEPTH: no stk_we; goto ERR; error=1, err_code=01, done=1 at N+1; depth unchanged.
REQ-028 Ret with depth==0: no stk_we; goto ERR; error=1, err_code=10, done=1 at N+1; ret_pc unchanged.
REQ-029 ERR holds busy=1 until clear_err is sampled high; next cycle error=0, err_code=00, state IDLE.
REQ-030 depth never wraps; it saturates logically via REQ-027/028.
REQ-031 stk_we is 00 in every state other than PUSH/POP.

Reset
REQ-032 reset_n low asynchronously forces: state IDLE, stk_we=00, stk_writedata=0, busy=0, done=0, ret_pc=0, error=0, err_code=00, depth=0.
REQ-033 Reset asserted mid-PUSH/POP aborts at once; stk_we drops without waiting for a clock edge; no done is issued.
REQ-034 First request is accepted on the first rising edge after reset_n deasserts.

Verification
REQ-035 Push F000, 0F00, 00F0, 000F (defaults) -> each: stk_we=01 for 2 cycles, done 3 cycles after request, depth 1,2,3,4.
REQ-036 From depth 4: pop, push 000F, pop, pop -> ret_pc 000F, 000F, 00F0; done 4 cycles after each ret_req; depth 3,4,3,2.
REQ-037 Push 8888, then pop x3 -> ret_pc 8888, 0F00, F000; final depth 0; extra pop -> error=1, err_code=10, done at N+1, stk_we stays 00.
REQ-038 16 pushes then one more call -> err_code=01, depth stays 16; call_req while in ERR dropped; clear_err -> error=0, busy=0 next cycle.
REQ-039 call_req and ret_req together at depth 2 -> push only, depth 3, ret_pc unchanged.
REQ-040 reset_n low during the second stk_we=10 cycle -> stk_we=00 immediately, depth=0, no done pulse.
